// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: drives word addresses to a combinational
// instruction memory and buffers fetched words in a 2-entry FIFO toward decode.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RESET | idle cycle after reset release, nothing fetched
// ST_FETCH | fetching at fetch_pc whenever the FIFO has (or frees) room
// ST_HALT  | fetch_pc out of range, no fetch; FIFO still drains
module instruction_fetch_unit #(
  parameter int unsigned MEM_WORDS = 101,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] read_address,
  input  logic [31:0] instruction,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_HALT} state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_WORDS - 1);
  localparam logic [5:0]  OP_J    = 6'b000010;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];

  logic       pop, push, in_range;
  logic [1:0] wr_sum;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;

    pop      = (count_q != 2'd0) && instr_ready;
    in_range = (fetch_pc_q <= LAST_PC);
    push     = (state_q == ST_FETCH) && !redirect && in_range &&
               ((count_q != 2'd2) || pop);
    // Slot for the new entry after an optional shift-out of the head.
    wr_sum   = count_q - {1'b0, pop};

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: if (!in_range) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase

    if (redirect) begin
      // A head accepted in this same cycle still counts as delivered.
      state_d    = ST_FETCH;
      fetch_pc_d = redirect_pc;
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        ent_pc_d[0]    = ent_pc_q[1];
        ent_instr_d[0] = ent_instr_q[1];
      end
      if (push) begin
        ent_pc_d[wr_sum[0]]    = fetch_pc_q;
        ent_instr_d[wr_sum[0]] = instruction;
        if (instruction[31:26] == OP_J)
          fetch_pc_d = {fetch_pc_q[31:26], instruction[25:0]};
        else
          fetch_pc_d = fetch_pc_q + 32'd1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
    end
  end

  assign read_address = fetch_pc_q;
  assign instr_valid  = (count_q != 2'd0);
  assign instr_out    = instr_valid ? ent_instr_q[0] : '0;
  assign pc_out       = instr_valid ? ent_pc_q[0] : '0;
  assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random decode
// back-pressure, redirects and resets, checked every cycle against a queue model.
module tb_instruction_fetch_unit;

  localparam int unsigned MEM_WORDS = 101;
  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam int M_RESET = 0, M_FETCH = 1, M_HALT = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] read_address, instruction, instr_out, pc_out, redirect_pc;
  logic        instr_valid, instr_ready, redirect, halted;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  int          m_mode;

  instruction_fetch_unit #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read_address (read_address),
    .instruction  (instruction),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  assign instruction = (read_address < 32'd128) ? mem[read_address[6:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] ei, ep;
    ev = (mq.size() != 0);
    ei = ev ? mq[0].ins : 32'h0;
    ep = ev ? mq[0].pc  : 32'h0;
    chk("read_address", read_address, m_fpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
    chk("instr_out", instr_out, ei);
    chk("pc_out", pc_out, ep);
    chk("halted", {31'b0, halted}, {31'b0, (m_mode == M_HALT)});
  endtask

  // Predicts the effect of the next rising edge from the spec's rules.
  task automatic model_edge(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    if (rd) begin
      mq.delete();
      m_fpc  = rpc;
      m_mode = M_FETCH;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (m_mode == M_RESET) begin
        m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (m_fpc > MEM_WORDS - 1) begin
          m_mode = M_HALT;
        end else if (mq.size() < 2) begin
          w = mem[m_fpc[6:0]];
          mq.push_back('{pc: m_fpc, ins: w});
          if (w[31:26] == 6'b000010) m_fpc = {m_fpc[31:26], w[25:0]};
          else m_fpc = m_fpc + 32'd1;
        end
      end
    end
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clock);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    check_outputs();
    model_edge(rdy, rd, rpc);
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc  = RESET_PC;
    m_mode = M_RESET;
  endtask

  // Release happens at a negedge, so the following rising edge is modelled here.
  task automatic release_reset(input logic rdy);
    @(negedge clock);
    reset_n     = 1'b1;
    instr_ready = rdy;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    check_outputs();
    model_edge(rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input logic rdy_after);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    instr_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
    release_reset(rdy_after);
  endtask

  initial begin
    logic [31:0] w;
    int          r;
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b000010) w[31] = 1'b1;
      mem[i] = w;
    end
    mem[12] = 32'h0800_007F;
    mem[40] = 32'h0800_0005;
    mem[90] = 32'h0800_0064;

    reset_n     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clock);
    release_reset(1'b1);

    // Streaming with decode always ready.
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Back-pressure from reset, then drain back-to-back.
    do_reset(1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Redirect with two entries buffered.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'd8);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Jump at word 12 leaves the memory range and halts.
    step(1'b1, 1'b1, 32'd10);
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // Recover from halt.
    step(1'b1, 1'b1, 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Jump to the last valid word, then run off the end.
    step(1'b1, 1'b1, 32'd89);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Reset while two entries are buffered.
    step(1'b1, 1'b1, 32'd20);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    do_reset(1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < 70), (r < 40),
             (r < 10) ? 32'd100 : 32'($urandom_range(0, 105)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
